// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, control bundle, defaults.
package pipeline_hazard_ctrl_pkg;

    localparam int PCTRL_REG_W = 5;
    localparam int PCTRL_CNT_W = 32;

    typedef logic [PCTRL_REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } pctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic imem_ren;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pctrl_ctl_t;

    // Every latch and the PC advance, fetch requested, nothing flushed.
    function automatic pctrl_ctl_t pctrl_advance_all();
        pctrl_ctl_t c;
        c             = '0;
        c.pc_en       = 1'b1;
        c.imem_ren    = 1'b1;
        c.ifid_en     = 1'b1;
        c.idex_en     = 1'b1;
        c.exmem_en    = 1'b1;
        c.memwb_en    = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-control bus; stall_cycles exists only when PIPE_CTRL_PERF_EN is defined.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5
`ifdef PIPE_CTRL_PERF_EN
    , parameter int CNT_W = 32
`endif
);
    logic             ihit;
    logic             dhit;
    logic             dmem_req;
    logic             idex_memrd;
    logic [REG_W-1:0] idex_rd;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             branch_ex;
    logic             halt_ex;
    logic             halt_wb;

    logic pc_en;
    logic imem_ren;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic halted;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  ihit, dhit, dmem_req, idex_memrd, idex_rd, ifid_rs, ifid_rt,
               branch_ex, halt_ex, halt_wb,
        output pc_en, imem_ren, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
    );

    modport slave (
        output ihit, dhit, dmem_req, idex_memrd, idex_rd, ifid_rs, ifid_rt,
               branch_ex, halt_ex, halt_wb,
        input  pc_en, imem_ren, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
    );
`else
    modport master (
        input  ihit, dhit, dmem_req, idex_memrd, idex_rd, ifid_rs, ifid_rt,
               branch_ex, halt_ex, halt_wb,
        output pc_en, imem_ren, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted
    );

    modport slave (
        output ihit, dhit, dmem_req, idex_memrd, idex_rd, ifid_rs, ifid_rt,
               branch_ex, halt_ex, halt_wb,
        input  pc_en, imem_ren, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted
    );
`endif

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the sources of the instruction in ID.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             memrd,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             load_use
);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = memrd && (rd != '0) && ((rd == rs) || (rd == rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch/PC sequencer with D-miss wait and halt drain.
// Optional stall counter enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = PCTRL_REG_W,
    parameter int CNT_W = PCTRL_CNT_W
) (
    input  logic                   CLK,
    input  logic                   nRST,
    pipeline_hazard_ctrl_if.master pif
);

    pctrl_state_t state, state_n;
    pctrl_ctl_t   ctl;
    logic         load_use;
    logic         adv;
    logic         dmem_ok;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .memrd    (pif.idex_memrd),
        .rd       (pif.idex_rd),
        .rs       (pif.ifid_rs),
        .rt       (pif.ifid_rt),
        .load_use (load_use)
    );

    assign dmem_ok = ~pif.dmem_req | pif.dhit;
    assign adv     = pif.ihit & dmem_ok;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        ctl     = '0;
        state_n = state;
        unique case (state)
            RUN, DWAIT: begin
                // A pending data access owns the cache port, so fetch is withheld too.
                if ((state == DWAIT) ? !pif.dhit : (pif.dmem_req && !pif.dhit)) begin
                    state_n = DWAIT;
                end else begin
                    state_n      = RUN;
                    ctl.imem_ren = 1'b1;
                    if (adv) begin
                        if (pif.halt_ex) begin
                            ctl            = pctrl_advance_all();
                            ctl.pc_en      = 1'b0;
                            ctl.ifid_flush = 1'b1;
                            ctl.idex_flush = 1'b1;
                            state_n        = DRAIN;
                        end else if (pif.branch_ex) begin
                            ctl            = pctrl_advance_all();
                            ctl.ifid_flush = 1'b1;
                            ctl.idex_flush = 1'b1;
                        end else if (load_use) begin
                            ctl            = pctrl_advance_all();
                            ctl.pc_en      = 1'b0;
                            ctl.ifid_en    = 1'b0;
                            ctl.idex_flush = 1'b1;
                        end else begin
                            ctl = pctrl_advance_all();
                        end
                    end
                end
            end
            DRAIN: begin
                ctl.idex_en  = dmem_ok;
                ctl.exmem_en = dmem_ok;
                ctl.memwb_en = dmem_ok;
                if (pif.halt_wb) begin
                    state_n = HALTED;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // Reset holds every enable and flush low regardless of the decode above.
    assign pif.pc_en       = nRST & ctl.pc_en;
    assign pif.imem_ren    = nRST & ctl.imem_ren;
    assign pif.ifid_en     = nRST & ctl.ifid_en;
    assign pif.idex_en     = nRST & ctl.idex_en;
    assign pif.exmem_en    = nRST & ctl.exmem_en;
    assign pif.memwb_en    = nRST & ctl.memwb_en;
    assign pif.ifid_flush  = nRST & ctl.ifid_flush;
    assign pif.idex_flush  = nRST & ctl.idex_flush;
    assign pif.exmem_flush = nRST & ctl.exmem_flush;
    assign pif.halted      = (state == HALTED);

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if ((state != HALTED) && (!adv || load_use) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign pif.stall_cycles = stall_cnt;
`else
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end
`endif

endmodule
